// File: rtl/m72_pkg.sv
// Shared M72 board definitions used by the SDRAM CPU-channel logic.
// Holds the arbiter state encoding and the byte-enable width.
package m72_pkg;

  localparam int SDR_BE_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } sdr_arb_state_t;

endpackage

// File: rtl/sdr_read_cache.sv
// One-entry tag/data/valid store for A-side SDRAM reads; lookup is combinational.
// Fill wins over invalidate; invalidate only clears when the address matches the tag.
module sdr_read_cache #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W:1]   lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o,
  input  logic              fill_i,
  input  logic              inval_i,
  input  logic [ADDR_W:1]   upd_addr_i,
  input  logic [DATA_W-1:0] fill_data_i
);

  logic [ADDR_W:1]   tag_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  assign hit_o      = valid_q && (tag_q == lookup_addr_i);
  assign hit_data_o = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (fill_i) begin
      tag_q   <= upd_addr_i;
      data_q  <= fill_data_i;
      valid_q <= 1'b1;
    end else if (inval_i && (tag_q == upd_addr_i)) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sdr_cpu_arbiter.sv
// Shares the SDRAM CPU channel between the V30 bus (A) and the sound/DMA fetch (B), one transaction at a time.
// Define SDR_ARB_READ_CACHE_EN to add a one-entry A-side read cache.
module sdr_cpu_arbiter
  import m72_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic                CLK_32M,
  input  logic                reset,
  input  logic                a_req,
  input  logic [ADDR_W:1]     a_addr,
  input  logic                a_we,
  input  logic                a_writable,
  input  logic [SDR_BE_W-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_ready,
  input  logic                b_req,
  input  logic [ADDR_W:1]     b_addr,
  input  logic                b_we,
  input  logic [SDR_BE_W-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_ready,
  output logic                sdr_req,
  output logic [ADDR_W:1]     sdr_addr,
  output logic                sdr_we,
  output logic [SDR_BE_W-1:0] sdr_be,
  output logic [DATA_W-1:0]   sdr_wdata,
  input  logic                sdr_ack,
  input  logic [DATA_W-1:0]   sdr_rdata,
  output logic                busy
);

  sdr_arb_state_t      state_q;
  logic                last_b_q;
  logic                owner_b_q;
  logic                local_q;
  logic                sdr_req_q;
  logic [ADDR_W:1]     sdr_addr_q;
  logic                sdr_we_q;
  logic [SDR_BE_W-1:0] sdr_be_q;
  logic [DATA_W-1:0]   sdr_wdata_q;
  logic [DATA_W-1:0]   a_rdata_q;
  logic [DATA_W-1:0]   b_rdata_q;
  logic                a_ready_q;
  logic                b_ready_q;
  logic                busy_q;

  logic grant_a, grant_b, a_blocked, a_hit;

  assign grant_a   = a_req && (!b_req || last_b_q);
  assign grant_b   = b_req && !grant_a;
  assign a_blocked = a_we && !a_writable;

`ifdef SDR_ARB_READ_CACHE_EN
  logic              cache_hit;
  logic [DATA_W-1:0] cache_data;
  logic              hit_q;
  logic              ack_done;

  assign ack_done = (state_q == ISSUE) && sdr_ack;
  assign a_hit    = !a_we && cache_hit;

  sdr_read_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cache (
    .clk_i        (CLK_32M),
    .rst_i        (reset),
    .lookup_addr_i(a_addr),
    .hit_o        (cache_hit),
    .hit_data_o   (cache_data),
    .fill_i       (ack_done && !owner_b_q && !sdr_we_q),
    .inval_i      (ack_done && sdr_we_q),
    .upd_addr_i   (sdr_addr_q),
    .fill_data_i  (sdr_rdata)
  );

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) hit_q <= 1'b0;
    else if ((state_q == IDLE) && grant_a) hit_q <= a_hit;
  end
`else
  assign a_hit = 1'b0;
`endif

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      owner_b_q   <= 1'b0;
      local_q     <= 1'b0;
      sdr_req_q   <= 1'b0;
      sdr_addr_q  <= '0;
      sdr_we_q    <= 1'b0;
      sdr_be_q    <= '0;
      sdr_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_a || grant_b) begin
            busy_q    <= 1'b1;
            owner_b_q <= grant_b;
          end
          // Blocked writes and cache hits complete without touching SDRAM
          if (grant_a && (a_blocked || a_hit)) begin
            local_q <= 1'b1;
            state_q <= DONE;
          end else if (grant_a) begin
            sdr_req_q   <= 1'b1;
            sdr_addr_q  <= a_addr;
            sdr_we_q    <= a_we;
            sdr_be_q    <= a_be;
            sdr_wdata_q <= a_wdata;
            state_q     <= ISSUE;
          end else if (grant_b) begin
            sdr_req_q   <= 1'b1;
            sdr_addr_q  <= b_addr;
            sdr_we_q    <= b_we;
            sdr_be_q    <= b_be;
            sdr_wdata_q <= b_wdata;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdr_ack) begin
            sdr_req_q <= 1'b0;
            if (!sdr_we_q) begin
              if (owner_b_q) b_rdata_q <= sdr_rdata;
              else           a_rdata_q <= sdr_rdata;
            end
            a_ready_q <= !owner_b_q;
            b_ready_q <= owner_b_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // Local completions spend one extra DONE cycle so a_ready lands two cycles after the grant
          if (local_q) begin
            local_q   <= 1'b0;
            a_ready_q <= 1'b1;
`ifdef SDR_ARB_READ_CACHE_EN
            if (hit_q) a_rdata_q <= cache_data;
`endif
          end else begin
            last_b_q <= owner_b_q;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdr_req   = sdr_req_q;
  assign sdr_addr  = sdr_addr_q;
  assign sdr_we    = sdr_we_q;
  assign sdr_be    = sdr_be_q;
  assign sdr_wdata = sdr_wdata_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_ready   = a_ready_q;
  assign b_ready   = b_ready_q;
  assign busy      = busy_q;

endmodule

// File: doc/sdr_cpu_arbiter.md
# sdr_cpu_arbiter

Shares the single SDRAM CPU channel between the main V30 bus (addresses produced by the board-type address decode) and a secondary requester (sound-CPU sample fetch / DMA copy). It sequences one SDRAM transaction at a time with a request/acknowledge handshake, round-robins when both sides are pending, and blocks writes to non-writable regions. It sits between the address decode logic and the SDRAM controller.

## Interface
- `ADDR_W`, default 24: SDRAM word-address width, bits [ADDR_W:1].
- `DATA_W`, default 16: data width.
- `CLK_32M` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `a_req` in 1: CPU request, level, held until `a_ready`.
- `a_addr` in ADDR_W: CPU SDRAM word address.
- `a_we` in 1: CPU write.
- `a_writable` in 1: the decoded region accepts writes.
- `a_be` in 2: byte enables.
- `a_wdata` in DATA_W: write data.
- `a_rdata` out DATA_W: read data.
- `a_ready` out 1: one-cycle completion pulse.
- `b_req`, `b_addr`, `b_we`, `b_be`, `b_wdata`, `b_rdata`, `b_ready`: secondary requester, same semantics. B is always writable.
- `sdr_req` out 1: level, held until `sdr_ack`.
- `sdr_addr` out ADDR_W, `sdr_we` out 1, `sdr_be` out 2, `sdr_wdata` out DATA_W: SDRAM command.
- `sdr_ack` in 1: one-cycle pulse; `sdr_rdata` is valid in the same cycle.
- `sdr_rdata` in DATA_W: SDRAM read data.
- `busy` out 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE:** samples `a_req` and `b_req`.
  - If only one is set, grant it.
  - If both are set, grant the side not served last. The `last_b` flag resets to 1, so A wins the first tie.
  - Grant latches address, we, be and wdata into the command registers, drives `sdr_req`=1, and moves to ISSUE.
- **ISSUE:** holds the command stable. On `sdr_ack`, it captures `sdr_rdata` into the owner's rdata register, drops `sdr_req`, and moves to DONE.
- **DONE:** pulses the owner's `*_ready` for exactly one cycle, updates `last_b`, and returns to IDLE.
- **Blocked write:** an A write with `a_writable`=0 never reaches SDRAM. IDLE goes straight to DONE, `a_ready` pulses, and `a_rdata` is unchanged.
- `*_rdata` holds its last value until that side's next read completes.
- A requester must deassert or change its request in the cycle after `*_ready`. A request still asserted in IDLE is treated as a new transaction.
- Request inputs that change during ISSUE are ignored; the latched command wins.
- **Reset mid-transaction:** all outputs return to reset values immediately and FSM returns to IDLE. The SDRAM controller must tolerate `sdr_req` dropping without an ack.
- **Reset values:** `sdr_req`=0, `sdr_addr`=0, `sdr_we`=0, `sdr_be`=0, `sdr_wdata`=0, `a_rdata`=0, `b_rdata`=0, `a_ready`=0, `b_ready`=0, `busy`=0, `last_b`=1.

## Timing
- A request seen in IDLE at cycle N drives `sdr_req` high at N+1.
- `sdr_ack` at cycle M gives `*_ready` and valid rdata at M+1. The next grant can occur at M+2.
- A blocked write gives `a_ready` at N+2.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `SDR_ARB_READ_CACHE_EN` defined:
  - One-entry read cache for requester A, holding a tag of ADDR_W bits, data, and a valid bit.
  - An A read whose address equals the valid tag bypasses SDRAM and goes IDLE to DONE: `a_ready` at N+2 with cached data, no `sdr_req`.
  - Every completed SDRAM read by A refills the entry.
  - Any SDRAM write (A or B) to the tagged address clears valid. Reset clears valid.
  - B is never cached.
- Macro undefined: every A read goes to SDRAM and no cache registers exist.

## Structure
- Add `sdr_arb_state_t` (IDLE, ISSUE, DONE) to `m72_pkg`.
- Region base addresses come from the existing `m72_pkg` region constants; this block uses none directly.
- Optional sub-module `sdr_read_cache`, the one-entry tag/data/valid store, is instantiated only under `SDR_ARB_READ_CACHE_EN`.

## Test plan
- **Single A read:** `a_req`, `a_addr`=0x000100; SDRAM acks 5 cycles later with 0xBEEF. Expect `sdr_req` high at N+1, `a_ready` one cycle after ack, `a_rdata`=0xBEEF.
- **Simultaneous contention:** `a_req` and `b_req` both rise at cycle N. Expect A served first, then B. With both held continuously, grants alternate A,B,A,B across 4 transactions.
- **Blocked write:** A write with `a_writable`=0, `a_wdata`=0x1234. Expect no `sdr_req`, `a_ready` at N+2, `a_rdata` unchanged.
- **Mid-transaction reset:** B write in ISSUE, assert `reset` before `sdr_ack`. Expect `sdr_req`=0 and `busy`=0 immediately. After release, a fresh A read completes normally.
- **Cache hit (macro defined):** A reads 0x000200 (ack data 0x5555), then reads 0x000200 again. Expect `a_ready` at N+2 with 0x5555 and no `sdr_req`.
- **Cache invalidation (macro defined):** after the hit above, B writes 0x000200, then A reads 0x000200. Expect `sdr_req` issued.
